// File: rtl/act_skew_feeder_pkg.sv
// ============================================================================
// Module      : act_skew_feeder_pkg
// Description : Shared array geometry defaults, FSM state encoding and helper
//               function for the activation skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_skew_feeder_pkg;

    localparam int c_array_row  = 12;
    localparam int c_array_col  = 12;
    localparam int c_data_width = 8;
    localparam int c_seq_max    = 256;
    localparam int c_len_w      = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Cycles needed after the last transfer until column ARRAY_COL-1 has emptied.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage

`default_nettype wire

// File: rtl/act_skew_feeder_if.sv
// ============================================================================
// Module      : act_skew_feeder_if
// Description : Valid/ready activation vector stream into the skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface act_skew_feeder_if
    import act_skew_feeder_pkg::*;
#(
    parameter int WIDTH = c_array_row * c_data_width
) ();

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_act_vec;

    modport master (
        output s_valid,
        output s_act_vec,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_act_vec,
        output s_ready
    );

endinterface

`default_nettype wire

// File: rtl/act_skew_feeder_skew_delay_line.sv
// ============================================================================
// Module      : skew_delay_line
// Description : DEPTH-stage enabled shift register; q is the oldest stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (shift_en) begin
            r_pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/act_skew_feeder.sv
// ============================================================================
// Module      : act_skew_feeder
// Description : Skews activation vectors into the systolic array and tags
//               column-0 results. Build option SKEW_STALL_EN selects stall
//               mode (hold pipeline on idle input) instead of zero bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int ARRAY_ROW  = c_array_row,
    parameter int ARRAY_COL  = c_array_col,
    parameter int DATA_WIDTH = c_data_width,
    parameter int SEQ_MAX    = c_seq_max,
    parameter int LEN_W      = c_len_w
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [LEN_W-1:0]                seq_len,
    act_skew_feeder_if.slave                s,
    output logic [ARRAY_ROW*DATA_WIDTH-1:0] out_act_vec,
    output logic                            en_compute,
    output logic                            col0_psum_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int c_drain_len = drain_len(ARRAY_ROW, ARRAY_COL);
    localparam int c_dcnt_w    = $clog2(c_drain_len);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_acc_cnt;
    logic [c_dcnt_w-1:0]   r_drain_cnt;
    logic                  r_zero_done;
    logic [LEN_W-1:0]      w_len;
    logic                  w_xfer;
    logic                  w_drain_end;
    logic                  w_start_tile;
    logic                  w_start_empty;

    // Lengths beyond the tile capacity are clamped rather than overrunning.
    assign w_len = (seq_len > LEN_W'(SEQ_MAX)) ? LEN_W'(SEQ_MAX) : seq_len;

    assign w_start_tile  = (r_state == ST_IDLE) && start && (w_len != '0);
    assign w_start_empty = (r_state == ST_IDLE) && start && (w_len == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s.s_ready   = 1'b0;
        en_compute  = 1'b0;
        busy        = 1'b0;
        w_xfer      = 1'b0;
        w_drain_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_tile) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                s.s_ready = 1'b1;
                busy      = 1'b1;
                w_xfer    = s.s_valid;
`ifdef SKEW_STALL_EN
                en_compute = s.s_valid;
`else
                en_compute = 1'b1;
`endif
                if (w_xfer && (r_acc_cnt == (r_len - LEN_W'(1)))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                en_compute = 1'b1;
                if (r_drain_cnt == c_dcnt_w'(c_drain_len - 1)) begin
                    w_drain_end = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_drain_cnt <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_start_empty;
            if (w_start_tile) begin
                r_len     <= w_len;
                r_acc_cnt <= '0;
            end else if (w_xfer) begin
                r_acc_cnt <= r_acc_cnt + LEN_W'(1);
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + c_dcnt_w'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign done = w_drain_end | r_zero_done;

    // Lane r carries r+1 stages so row r enters the array r cycles after row 0.
    for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_head;

        assign w_head = w_xfer ? s.s_act_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (en_compute),
            .d        (w_head),
            .q        (out_act_vec[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Tag rides with lane 0 (one stage) then waits ARRAY_ROW more for column 0.
    skew_delay_line #(
        .DEPTH (ARRAY_ROW + 1),
        .WIDTH (1)
    ) u_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (en_compute),
        .d        (w_xfer),
        .q        (col0_psum_valid)
    );

endmodule

`default_nettype wire
